tdd_frame_engine: RTL and testbench
===================================

Name: tdd_frame_engine

Overview:
- Parametrised TDD timing core for the next-generation TDD controller.
- Runs the IDLE/ARMED/WAITING/RUNNING frame state machine: startup delay, frame counter, burst counting, internal or external sync, and resync while running.
- Generates CHANNEL_COUNT output channels. Each channel has WINDOW_COUNT independent on/off windows per frame, with wrap-around windows.
- Sits between the AXI register bank (configuration) and the device-facing TDD pins.

Parameters:
- CHANNEL_COUNT, 8, number of output channels (1..32).
- WINDOW_COUNT, 2, on/off windows per channel (1..4).
- COUNTER_WIDTH, 24, width of the frame counter, startup delay and window positions.
- BURST_WIDTH, 32, width of burst count and frame count.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- tdd_enable  in  1  level; 0 forces IDLE.
- tdd_sync_ext  in  1  1 = wait for tdd_sync in ARMED; 0 = start immediately.
- tdd_sync_rst  in  1  1 = a tdd_sync pulse in RUNNING restarts the frame.
- tdd_sync  in  1  single-cycle sync pulse, already synchronised to clk.
- tdd_startup_delay  in  COUNTER_WIDTH  cycles spent in WAITING.
- tdd_frame_length  in  COUNTER_WIDTH  last counter value of a frame (period = value+1).
- tdd_burst_count  in  BURST_WIDTH  frames per burst; 0 = infinite.
- tdd_ch_en  in  CHANNEL_COUNT  per-channel enable.
- tdd_ch_pol  in  CHANNEL_COUNT  per-channel inactive level.
- tdd_ch_on  in  CHANNEL_COUNT*WINDOW_COUNT*COUNTER_WIDTH  window start; slice index = c*WINDOW_COUNT+w.
- tdd_ch_off  in  CHANNEL_COUNT*WINDOW_COUNT*COUNTER_WIDTH  window end (exclusive); same layout as tdd_ch_on.
- tdd_cstate  out  2  current state: IDLE=0, ARMED=1, WAITING=2, RUNNING=3.
- tdd_counter  out  COUNTER_WIDTH  current counter value.
- tdd_frame_count  out  BURST_WIDTH  frames completed in this burst.
- tdd_endof_frame  out  1  pulse on the last cycle of each frame.
- tdd_channel  out  CHANNEL_COUNT  channel outputs.

Behaviour:
- Reset (async, rst=1):
  - tdd_cstate = IDLE; tdd_counter = 0; tdd_frame_count = 0; tdd_endof_frame = 0.
  - tdd_channel = 0 until the first clk edge after rst release, then tdd_ch_pol.
- IDLE:
  - Counter and frame count held at 0.
  - tdd_enable=1 → ARMED. On that transition, latch tdd_startup_delay, tdd_frame_length, tdd_burst_count, tdd_sync_ext and tdd_sync_rst.
  - Later changes to latched values are ignored until the next IDLE→ARMED.
  - Window and channel inputs are not latched; they are live.
- ARMED:
  - If sync_ext=0, or tdd_sync=1 this cycle: go to WAITING when delay≠0, else go straight to RUNNING.
- WAITING:
  - Counter counts 0..delay−1.
  - At count delay−1 → RUNNING, counter cleared to 0.
  - Total WAITING time is exactly delay cycles.
- RUNNING:
  - Counter counts 0..frame_length, then wraps to 0.
  - tdd_endof_frame=1 (registered, aligned with tdd_counter) when counter==frame_length.
  - frame_count increments on the wrap.
  - If burst≠0 and the frame just completed is frame number burst: go to IDLE instead of wrapping; counter=0, frame_count=0.
  - frame_length=0 gives a 1-cycle frame with endof_frame high every cycle.
- Resync:
  - Applies in RUNNING with sync_rst=1 and tdd_sync=1: counter goes to 0 next cycle.
  - frame_count is not incremented and endof_frame is not asserted.
  - If resync coincides with counter==frame_length, the normal end of frame wins.
- tdd_enable=0 in any state → IDLE on the next edge. This overrides every other transition.
- Window activity, evaluated on tdd_counter in RUNNING only:
  - on<off: active when on ≤ counter < off.
  - on>off (wrap): active when counter ≥ on OR counter < off.
  - on==off: window disabled.
  - Window positions beyond frame_length never match their out-of-range edge.
- Channel output (registered, 1 cycle after tdd_counter/tdd_cstate):
  - tdd_channel[c] = pol[c] XOR (en[c] AND RUNNING AND OR over w of window active).
  - Outside RUNNING every channel sits at pol[c].
  - After RUNNING→IDLE, channels return to pol one cycle after tdd_cstate changes.
- Counter and frame count saturate nowhere. Widths are sufficient by construction; wrap at 2^BURST_WIDTH is permitted for infinite bursts.

Test Plan:
- Basic burst: delay=3, frame_length=9, burst=2, ch0 on=2 off=5, pol=0, sync_ext=0.
  - Required: ARMED 1 cycle, WAITING 3 cycles, 20 RUNNING cycles.
  - ch0 high for counter 2..4 (output lags by 1) in both frames.
  - endof_frame high at counter 9 twice, then IDLE.
- Wrap window plus second window: frame_length=9, ch1 window0 on=8 off=2, window1 on=5 off=6, pol=1, burst=0.
  - Required: ch1 low at counter 8,9,0,1,5 and high elsewhere, repeating indefinitely.
- External sync: sync_ext=1, hold 50 cycles with no tdd_sync.
  - Required: stays ARMED, counter 0, channels at pol.
  - Pulse tdd_sync → WAITING next cycle.
- Resync: sync_rst=1, frame_length=99, pulse tdd_sync at counter 40.
  - Required: counter 0 next cycle, frame_count unchanged.
  - Pulse tdd_sync at counter 99: normal wrap, frame_count+1.
- Abort and reset mid-run: deassert tdd_enable at counter 5 of frame 1.
  - Required: IDLE next edge, counter=0, channels=pol one cycle later.
  - Assert rst asynchronously mid-RUNNING: all outputs reset without a clk edge.
- Edge cases:
  - frame_length=0, burst=3: endof_frame high 3 consecutive cycles, then IDLE.
  - delay=0: ARMED→RUNNING directly.
  - on==off: channel stays at pol.

Source files
------------

// File: rtl/tdd_frame_engine.sv
// TDD frame timing core: IDLE/ARMED/WAITING/RUNNING sequencing, frame/burst counting, per-channel on/off windows.
// Latency: tdd_cstate/tdd_counter/tdd_endof_frame registered together; tdd_channel lags them by one cycle.
// Backpressure: none; free-running timing engine driven by level/pulse controls.
module tdd_frame_engine #(
    parameter int CHANNEL_COUNT = 8,
    parameter int WINDOW_COUNT  = 2,
    parameter int COUNTER_WIDTH = 24,
    parameter int BURST_WIDTH   = 32
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           tdd_enable,
    input  logic                                           tdd_sync_ext,
    input  logic                                           tdd_sync_rst,
    input  logic                                           tdd_sync,
    input  logic [COUNTER_WIDTH-1:0]                       tdd_startup_delay,
    input  logic [COUNTER_WIDTH-1:0]                       tdd_frame_length,
    input  logic [BURST_WIDTH-1:0]                         tdd_burst_count,
    input  logic [CHANNEL_COUNT-1:0]                       tdd_ch_en,
    input  logic [CHANNEL_COUNT-1:0]                       tdd_ch_pol,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*COUNTER_WIDTH-1:0] tdd_ch_on,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*COUNTER_WIDTH-1:0] tdd_ch_off,
    output logic [1:0]                                     tdd_cstate,
    output logic [COUNTER_WIDTH-1:0]                       tdd_counter,
    output logic [BURST_WIDTH-1:0]                         tdd_frame_count,
    output logic                                           tdd_endof_frame,
    output logic [CHANNEL_COUNT-1:0]                       tdd_channel
);

    localparam int NW = CHANNEL_COUNT * WINDOW_COUNT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_WAITING = 2'd2,
        ST_RUNNING = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [COUNTER_WIDTH-1:0]   counter_q, counter_d;
    logic [BURST_WIDTH-1:0]     frame_count_q, frame_count_d;
    logic                       eof_q, eof_d;
    logic [CHANNEL_COUNT-1:0]   channel_q, channel_d;

    // Configuration snapshot taken on IDLE->ARMED so a run is immune to register writes.
    logic [COUNTER_WIDTH-1:0]   delay_q, delay_d;
    logic [COUNTER_WIDTH-1:0]   frame_len_q, frame_len_d;
    logic [BURST_WIDTH-1:0]     burst_q, burst_d;
    logic                       sync_ext_q, sync_ext_d;
    logic                       sync_rst_q, sync_rst_d;

    logic [NW-1:0]              win_hit;
    logic [CHANNEL_COUNT-1:0]   ch_active;

    // Window match on the live window registers; on>off wraps across the frame boundary, on==off never matches.
    for (genvar gi = 0; gi < NW; gi++) begin : g_win
        logic [COUNTER_WIDTH-1:0] on_v;
        logic [COUNTER_WIDTH-1:0] off_v;
        assign on_v  = tdd_ch_on[gi*COUNTER_WIDTH +: COUNTER_WIDTH];
        assign off_v = tdd_ch_off[gi*COUNTER_WIDTH +: COUNTER_WIDTH];
        assign win_hit[gi] = (on_v < off_v) ? ((counter_q >= on_v) && (counter_q < off_v)) :
                             (on_v > off_v) ? ((counter_q >= on_v) || (counter_q < off_v)) :
                                              1'b0;
    end

    // OR all windows belonging to each channel.
    always_comb begin
        ch_active = '0;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            for (int w = 0; w < WINDOW_COUNT; w++) begin
                ch_active[c] = ch_active[c] | win_hit[c*WINDOW_COUNT + w];
            end
        end
    end

    // Next-state, counter, frame count and end-of-frame; disable overrides everything.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        frame_count_d = frame_count_q;
        delay_d       = delay_q;
        frame_len_d   = frame_len_q;
        burst_d       = burst_q;
        sync_ext_d    = sync_ext_q;
        sync_rst_d    = sync_rst_q;

        case (state_q)
            ST_IDLE: begin
                counter_d     = '0;
                frame_count_d = '0;
                if (tdd_enable) begin
                    state_d     = ST_ARMED;
                    delay_d     = tdd_startup_delay;
                    frame_len_d = tdd_frame_length;
                    burst_d     = tdd_burst_count;
                    sync_ext_d  = tdd_sync_ext;
                    sync_rst_d  = tdd_sync_rst;
                end
            end
            ST_ARMED: begin
                counter_d     = '0;
                frame_count_d = '0;
                if (!sync_ext_q || tdd_sync) begin
                    state_d = (delay_q != '0) ? ST_WAITING : ST_RUNNING;
                end
            end
            ST_WAITING: begin
                if (counter_q == delay_q - COUNTER_WIDTH'(1)) begin
                    state_d   = ST_RUNNING;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + COUNTER_WIDTH'(1);
                end
            end
            ST_RUNNING: begin
                // A normal end of frame takes priority over a coincident resync.
                if (counter_q == frame_len_q) begin
                    counter_d = '0;
                    if ((burst_q != '0) && (frame_count_q + BURST_WIDTH'(1) == burst_q)) begin
                        state_d       = ST_IDLE;
                        frame_count_d = '0;
                    end else begin
                        frame_count_d = frame_count_q + BURST_WIDTH'(1);
                    end
                end else if (sync_rst_q && tdd_sync) begin
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + COUNTER_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!tdd_enable) begin
            state_d       = ST_IDLE;
            counter_d     = '0;
            frame_count_d = '0;
        end

        // Registered end-of-frame stays aligned with the counter value it flags.
        eof_d = (state_d == ST_RUNNING) && (counter_d == frame_len_d);
    end

    // Channels follow the registered state/counter, hence one cycle behind them.
    always_comb begin
        channel_d = tdd_ch_pol ^ (tdd_ch_en & ch_active & {CHANNEL_COUNT{state_q == ST_RUNNING}});
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            frame_count_q <= '0;
            eof_q         <= 1'b0;
            channel_q     <= '0;
            delay_q       <= '0;
            frame_len_q   <= '0;
            burst_q       <= '0;
            sync_ext_q    <= 1'b0;
            sync_rst_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            frame_count_q <= frame_count_d;
            eof_q         <= eof_d;
            channel_q     <= channel_d;
            delay_q       <= delay_d;
            frame_len_q   <= frame_len_d;
            burst_q       <= burst_d;
            sync_ext_q    <= sync_ext_d;
            sync_rst_q    <= sync_rst_d;
        end
    end

    assign tdd_cstate      = state_q;
    assign tdd_counter     = counter_q;
    assign tdd_frame_count = frame_count_q;
    assign tdd_endof_frame = eof_q;
    assign tdd_channel     = channel_q;

endmodule

// File: tb/tb_tdd_frame_engine.sv
// Bench for tdd_frame_engine: directed plan scenarios plus randomized configurations against a timeline model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable.
module tb_tdd_frame_engine;
    localparam int CH = 8;
    localparam int WC = 2;
    localparam int CW = 24;
    localparam int BW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              tdd_enable = 1'b0;
    logic              tdd_sync_ext = 1'b0;
    logic              tdd_sync_rst = 1'b0;
    logic              tdd_sync = 1'b0;
    logic [CW-1:0]     tdd_startup_delay = '0;
    logic [CW-1:0]     tdd_frame_length = '0;
    logic [BW-1:0]     tdd_burst_count = '0;
    logic [CH-1:0]     tdd_ch_en = '0;
    logic [CH-1:0]     tdd_ch_pol = '0;
    logic [CH*WC*CW-1:0] tdd_ch_on = '0;
    logic [CH*WC*CW-1:0] tdd_ch_off = '0;
    logic [1:0]        tdd_cstate;
    logic [CW-1:0]     tdd_counter;
    logic [BW-1:0]     tdd_frame_count;
    logic              tdd_endof_frame;
    logic [CH-1:0]     tdd_channel;

    int total = 0;
    int bad = 0;

    tdd_frame_engine #(
        .CHANNEL_COUNT(CH), .WINDOW_COUNT(WC), .COUNTER_WIDTH(CW), .BURST_WIDTH(BW)
    ) dut (
        .clk(clk), .rst(rst), .tdd_enable(tdd_enable), .tdd_sync_ext(tdd_sync_ext),
        .tdd_sync_rst(tdd_sync_rst), .tdd_sync(tdd_sync), .tdd_startup_delay(tdd_startup_delay),
        .tdd_frame_length(tdd_frame_length), .tdd_burst_count(tdd_burst_count),
        .tdd_ch_en(tdd_ch_en), .tdd_ch_pol(tdd_ch_pol), .tdd_ch_on(tdd_ch_on), .tdd_ch_off(tdd_ch_off),
        .tdd_cstate(tdd_cstate), .tdd_counter(tdd_counter), .tdd_frame_count(tdd_frame_count),
        .tdd_endof_frame(tdd_endof_frame), .tdd_channel(tdd_channel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input int c, input int w, input int on, input int off);
        tdd_ch_on[(c*WC+w)*CW +: CW]  = CW'(on);
        tdd_ch_off[(c*WC+w)*CW +: CW] = CW'(off);
    endtask

    task automatic clear_wins();
        tdd_ch_on  = '0;
        tdd_ch_off = '0;
    endtask

    // Active iff the distance from on to cnt, modulo the counter range, is shorter than the window span.
    function automatic bit win_hit(input longint cnt, input longint on, input longint off);
        longint m;
        m = longint'(1) << CW;
        return ((cnt - on + m) % m) < ((off - on + m) % m);
    endfunction

    function automatic logic [CH-1:0] exp_ch(input bit running, input int cnt);
        logic [CH-1:0] r;
        bit act;
        for (int c = 0; c < CH; c++) begin
            act = 1'b0;
            for (int w = 0; w < WC; w++) begin
                act = act | win_hit(longint'(cnt),
                                    longint'(tdd_ch_on[(c*WC+w)*CW +: CW]),
                                    longint'(tdd_ch_off[(c*WC+w)*CW +: CW]));
            end
            r[c] = tdd_ch_pol[c] ^ (tdd_ch_en[c] & running & act);
        end
        return r;
    endfunction

    // Timeline: k edges after enable was first seen in IDLE. One cycle ARMED, delay cycles WAITING,
    // burst*(fl+1) cycles RUNNING, one cycle IDLE, then the cycle repeats (infinite when burst==0).
    task automatic model(input int k, input int delay, input int fl, input int burst,
                         output int st, output int cnt, output int fc);
        longint p, per, len, r;
        per = longint'(fl) + 1;
        st = 0; cnt = 0; fc = 0;
        if (k == 0) return;
        if (burst == 0) p = k - 1;
        else begin
            len = 2 + delay + burst * per;
            p = (k - 1) % len;
        end
        if (p == 0) st = 1;
        else if (p <= delay) begin
            st = 2; cnt = int'(p - 1);
        end else begin
            r = p - delay - 1;
            if (burst != 0 && r >= burst * per) st = 0;
            else begin
                st = 3; cnt = int'(r % per); fc = int'(r / per);
            end
        end
    endtask

    task automatic run_scenario(input int delay, input int fl, input int burst, input int ncyc,
                                output int n_run, output int n_eof);
        int st, cnt, fc, pst, pcnt;
        tdd_enable = 1'b0;
        tick();
        tdd_startup_delay = CW'(delay);
        tdd_frame_length  = CW'(fl);
        tdd_burst_count   = BW'(burst);
        tdd_sync_ext = 1'b0;
        tdd_sync_rst = 1'b0;
        tdd_sync     = 1'b0;
        tdd_enable   = 1'b1;
        pst = 0; pcnt = 0; n_run = 0; n_eof = 0;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            model(k, delay, fl, burst, st, cnt, fc);
            check("cstate", tdd_cstate, st);
            check("counter", tdd_counter, cnt);
            check("frame_count", tdd_frame_count, fc);
            check("endof_frame", tdd_endof_frame, (st == 3 && cnt == fl) ? 1 : 0);
            check("channel", tdd_channel, exp_ch(pst == 3, pcnt));
            if (tdd_cstate == 2'd3) n_run++;
            if (tdd_endof_frame) n_eof++;
            pst = st; pcnt = cnt;
        end
    endtask

    task automatic wait_for(input int st, input int fc, input int cnt, input int budget);
        int n;
        bit reached;
        n = 0;
        reached = (tdd_cstate == 2'(st)) && (tdd_frame_count == BW'(fc)) && (tdd_counter == CW'(cnt));
        while (!reached && n < budget) begin
            tick();
            n++;
            reached = (tdd_cstate == 2'(st)) && (tdd_frame_count == BW'(fc)) && (tdd_counter == CW'(cnt));
        end
        check("wait_reached", reached, 1);
    endtask

    initial begin
        int n_run, n_eof, fc0, d, fl, b, len;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_cstate", tdd_cstate, 0);
        check("rst_counter", tdd_counter, 0);
        check("rst_channel", tdd_channel, 0);
        tdd_ch_pol = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_channel", tdd_channel, 0);
        check("rst_held_eof", tdd_endof_frame, 0);
        check("rst_held_fc", tdd_frame_count, 0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_release_channel", tdd_channel, 0);
        tick();
        check("post_rst_channel", tdd_channel, 8'h5A);
        check("post_rst_cstate", tdd_cstate, 0);

        // Basic burst
        clear_wins();
        set_win(0, 0, 2, 5);
        tdd_ch_en = 8'h01; tdd_ch_pol = 8'h00;
        run_scenario(3, 9, 2, 25, n_run, n_eof);
        check("basic_run_cycles", n_run, 20);
        check("basic_eof_count", n_eof, 2);

        // Wrap window plus second window, infinite burst
        clear_wins();
        set_win(1, 0, 8, 2);
        set_win(1, 1, 5, 6);
        tdd_ch_en = 8'h02; tdd_ch_pol = 8'h02;
        run_scenario(0, 9, 0, 40, n_run, n_eof);
        check("wrap_eof_count", n_eof, 3);

        // One-cycle frames, zero delay, disabled (on==off) window
        clear_wins();
        set_win(2, 0, 0, 0);
        tdd_ch_en = 8'h04; tdd_ch_pol = 8'h04;
        run_scenario(0, 0, 3, 5, n_run, n_eof);
        check("fl0_eof_count", n_eof, 3);
        check("fl0_run_cycles", n_run, 3);

        // Randomized configurations
        for (int s = 0; s < 8; s++) begin
            d  = int'($urandom_range(0, 4));
            fl = int'($urandom_range(0, 12));
            b  = int'($urandom_range(0, 3));
            for (int c = 0; c < CH; c++)
                for (int w = 0; w < WC; w++)
                    set_win(c, w, int'($urandom_range(0, fl + 2)), int'($urandom_range(0, fl + 2)));
            tdd_ch_en  = CH'($urandom);
            tdd_ch_pol = CH'($urandom);
            len = (b == 0) ? 40 : 2 * (2 + d + b * (fl + 1)) + 2;
            if (len > 200) len = 200;
            run_scenario(d, fl, b, len, n_run, n_eof);
        end

        // External sync: wait in ARMED until the pulse
        clear_wins();
        for (int c = 0; c < CH; c++) set_win(c, 0, 0, 9);
        tdd_ch_en = 8'hFF; tdd_ch_pol = 8'hA5;
        tdd_enable = 1'b0;
        tick();
        tdd_startup_delay = 24'd2; tdd_frame_length = 24'd9; tdd_burst_count = 32'd0;
        tdd_sync_ext = 1'b1; tdd_sync_rst = 1'b0;
        tdd_enable = 1'b1;
        tick();
        check("ext_armed", tdd_cstate, 1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("ext_hold_cstate", tdd_cstate, 1);
            check("ext_hold_counter", tdd_counter, 0);
            check("ext_hold_channel", tdd_channel, 8'hA5);
        end
        tdd_sync = 1'b1;
        tick();
        tdd_sync = 1'b0;
        check("ext_waiting", tdd_cstate, 2);
        check("ext_wait_counter", tdd_counter, 0);
        tick();
        check("ext_wait_counter1", tdd_counter, 1);
        tick();
        check("ext_running", tdd_cstate, 3);

        // Resync mid-frame and at end of frame
        tdd_enable = 1'b0;
        tick();
        tdd_startup_delay = 24'd0; tdd_frame_length = 24'd99;
        tdd_sync_ext = 1'b0; tdd_sync_rst = 1'b1;
        tdd_enable = 1'b1;
        wait_for(3, 0, 40, 200);
        fc0 = int'(tdd_frame_count);
        tdd_sync = 1'b1;
        tick();
        tdd_sync = 1'b0;
        check("resync_counter", tdd_counter, 0);
        check("resync_fc", tdd_frame_count, fc0);
        check("resync_eof", tdd_endof_frame, 0);
        wait_for(3, 0, 99, 200);
        check("resync_eof_at_end", tdd_endof_frame, 1);
        fc0 = int'(tdd_frame_count);
        tdd_sync = 1'b1;
        tick();
        tdd_sync = 1'b0;
        check("resync_end_counter", tdd_counter, 0);
        check("resync_end_fc", tdd_frame_count, fc0 + 1);
        check("resync_end_cstate", tdd_cstate, 3);

        // Abort via tdd_enable
        tdd_enable = 1'b0;
        tick();
        tdd_frame_length = 24'd9; tdd_sync_rst = 1'b0;
        tdd_enable = 1'b1;
        wait_for(3, 1, 5, 100);
        check("abort_pre_channel", tdd_channel, 8'h5A);
        tdd_enable = 1'b0;
        tick();
        check("abort_cstate", tdd_cstate, 0);
        check("abort_counter", tdd_counter, 0);
        check("abort_fc", tdd_frame_count, 0);
        tick();
        check("abort_channel", tdd_channel, 8'hA5);

        // Asynchronous reset mid-run
        tdd_enable = 1'b1;
        wait_for(3, 0, 3, 100);
        #2 rst = 1'b1;
        #1;
        check("arst_cstate", tdd_cstate, 0);
        check("arst_counter", tdd_counter, 0);
        check("arst_fc", tdd_frame_count, 0);
        check("arst_eof", tdd_endof_frame, 0);
        check("arst_channel", tdd_channel, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("arst_release_cstate", tdd_cstate, 1);
        check("arst_release_channel", tdd_channel, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
